ldd_seq_ctrl: RTL

Sequencer and arbiter in front of the laser-diode driver top. Two requesters share the single LDD channel: a host command-pulse requester and a capture requester. The block grants one request at a time and owns `cap_mode`. On a mode change it inserts a dead-time guard, because the change resets the inactive driver path. It then drives either the command open/close pair or the capture trigger, and reports completion.

---
 rtl/ldd_seq_pkg.sv | 28 ++
 rtl/ldd_seq_arb.sv | 39 +++
 rtl/ldd_seq_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ldd_seq_pkg.sv
// Shared types and defaults for the LDD channel sequencer/arbiter.
package ldd_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGuard,
        StComRun,
        StComClose,
        StCapTrig,
        StCapWait
    } state_e;

    typedef enum logic {
        GntCom = 1'b0,
        GntCap = 1'b1
    } grant_e;

    localparam int unsigned GuardCycDefault = 16;
    localparam int unsigned CapTmoDefault   = 4096;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ldd_seq_arb.sv
// Two-requester round-robin arbiter; grant is one-hot {cap, com} and only valid while en_i.
module ldd_seq_arb
    import ldd_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       com_req_i,
    input  logic       cap_req_i,
    output logic [1:0] gnt_o
);

    grant_e last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (com_req_i && cap_req_i) begin
                // Tie: the path not served last time wins.
                gnt_o = (last_q == GntCom) ? 2'b10 : 2'b01;
            end else if (com_req_i) begin
                gnt_o = 2'b01;
            end else if (cap_req_i) begin
                gnt_o = 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= GntCom;
        end else if (gnt_o[1]) begin
            last_q <= GntCap;
        end else if (gnt_o[0]) begin
            last_q <= GntCom;
        end
    end

endmodule

// File: rtl/ldd_seq_ctrl.sv
// Sequencer in front of the LDD: grants command or capture, guards mode changes,
// drives the selected driver path and reports capture completion or timeout.
module ldd_seq_ctrl
    import ldd_seq_pkg::*;
#(
    parameter int unsigned TOP0_0    = 3,
    parameter int unsigned LDD0_0    = 32,
    parameter int unsigned GUARD_CYC = GuardCycDefault,
    parameter int unsigned CAP_TMO   = CapTmoDefault
) (
    input  logic              clk200,
    input  logic              rst,
    input  logic              com_req,
    input  logic [TOP0_0-1:0] com_req_wdis,
    input  logic [LDD0_0-1:0] com_req_plus,
    output logic              com_ack,
    input  logic              cap_req,
    input  logic [TOP0_0-1:0] cap_req_wdis,
    input  logic [LDD0_0-1:0] cap_req_plus,
    output logic              cap_ack,
    output logic              cap_done,
    output logic              cap_err,
    output logic              busy,
    output logic              cap_mode,
    output logic [TOP0_0-1:0] cap_wdis,
    output logic [LDD0_0-1:0] cap_plus,
    output logic              cap_trig,
    input  logic              capr_rdy,
    output logic [TOP0_0-1:0] com_wdis,
    output logic [LDD0_0-1:0] com_plus,
    output logic              com_open,
    output logic              com_close
);

    localparam int unsigned CntW = max3(LDD0_0, int'($clog2(CAP_TMO + 1)),
                                        int'($clog2(GUARD_CYC + 1)));
    localparam logic [CntW-1:0] GuardLoad = CntW'(GUARD_CYC);
    localparam logic [CntW-1:0] TmoLoad   = CntW'(CAP_TMO);

    // A zero-length command pulse is stretched to one cycle.
    function automatic logic [CntW-1:0] pulse_len(input logic [LDD0_0-1:0] p);
        return (p == '0) ? CntW'(1) : CntW'(p);
    endfunction

    state_e          state_q;
    grant_e          sel_q;
    logic [CntW-1:0] cnt_q;
    logic            rdy_q;
    logic [1:0]      gnt;

    ldd_seq_arb u_arb (
        .clk_i     (clk200),
        .rst_i     (rst),
        .en_i      (state_q == StIdle),
        .com_req_i (com_req),
        .cap_req_i (cap_req),
        .gnt_o     (gnt)
    );

    always_ff @(posedge clk200) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= GntCom;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            com_ack   <= 1'b0;
            cap_ack   <= 1'b0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
            busy      <= 1'b0;
            cap_mode  <= 1'b0;
            cap_wdis  <= '0;
            cap_plus  <= '0;
            cap_trig  <= 1'b0;
            com_wdis  <= '0;
            com_plus  <= '0;
            com_open  <= 1'b0;
            com_close <= 1'b0;
        end else begin
            com_ack   <= 1'b0;
            cap_ack   <= 1'b0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
            cap_trig  <= 1'b0;
            com_open  <= 1'b0;
            com_close <= 1'b0;
            // Tracks the level every cycle, so a level already high at trigger never counts.
            rdy_q     <= capr_rdy;

            unique case (state_q)
                StIdle: begin
                    if (gnt[0]) begin
                        com_ack  <= 1'b1;
                        com_wdis <= com_req_wdis;
                        com_plus <= com_req_plus;
                        sel_q    <= GntCom;
                        busy     <= 1'b1;
                        if (cap_mode) begin
                            cap_mode <= 1'b0;
                            cnt_q    <= GuardLoad;
                            state_q  <= StGuard;
                        end else begin
                            com_open <= 1'b1;
                            cnt_q    <= pulse_len(com_req_plus);
                            state_q  <= StComRun;
                        end
                    end else if (gnt[1]) begin
                        cap_ack  <= 1'b1;
                        cap_wdis <= cap_req_wdis;
                        cap_plus <= cap_req_plus;
                        sel_q    <= GntCap;
                        busy     <= 1'b1;
                        if (!cap_mode) begin
                            cap_mode <= 1'b1;
                            cnt_q    <= GuardLoad;
                            state_q  <= StGuard;
                        end else begin
                            state_q <= StCapTrig;
                        end
                    end
                end
                StGuard: begin
                    if (cnt_q == '0) begin
                        if (sel_q == GntCap) begin
                            // Guard exit issues the trigger itself to land at grant+2+GUARD_CYC.
                            cap_trig <= 1'b1;
                            cnt_q    <= TmoLoad;
                            state_q  <= StCapWait;
                        end else begin
                            com_open <= 1'b1;
                            cnt_q    <= pulse_len(com_plus);
                            state_q  <= StComRun;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StComRun: begin
                    if (cnt_q <= CntW'(1)) begin
                        com_close <= 1'b1;
                        state_q   <= StComClose;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StComClose: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                StCapTrig: begin
                    cap_trig <= 1'b1;
                    cnt_q    <= TmoLoad;
                    state_q  <= StCapWait;
                end
                StCapWait: begin
                    // Result pulse cycle stays in CAP_WAIT; IDLE follows it.
                    if (cap_done || cap_err) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (capr_rdy && !rdy_q) begin
                        cap_done <= 1'b1;
                    end else if (cnt_q == '0) begin
                        cap_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
